// File: rtl/ecc_pkg.sv
// ecc_pkg
// Shared constants for the GF(2^128) ALU command sequencer: datapath and
// register-address widths, command opcodes, the sequencer state encoding
// and the default watchdog limit.
package ecc_pkg;

    localparam int ECC_DATA_W         = 128;
    localparam int ECC_NREGS          = 8;
    localparam int ECC_AW             = 3;
    localparam int ECC_TIMEOUT_CYCLES = 255;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_MULT = 2'b01;
    localparam logic [1:0] OP_SQR  = 2'b10;
    localparam logic [1:0] OP_MOV  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/ecc_regfile.sv
// ecc_regfile
// NREGS x DATA_W operand register file for the ALU sequencer.
// Ports:
//   clk_i              clock, rising edge
//   rst_ni             synchronous active-low clear of every entry
//   we_i/waddr_i/wdata_i   single synchronous write port
//   raddr_a_i/rdata_a_o    combinational read port (operand A)
//   raddr_b_i/rdata_b_o    combinational read port (operand B)
//   raddr_c_i/rdata_c_o    combinational read port (host read)
module ecc_regfile
    import ecc_pkg::*;
#(
    parameter int DATA_W = ECC_DATA_W,
    parameter int NREGS  = ECC_NREGS,
    parameter int AW     = ECC_AW
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [AW-1:0]     raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic [AW-1:0]     raddr_c_i,
    output logic [DATA_W-1:0] rdata_c_o
);

    logic [DATA_W-1:0] mem_q [NREGS];

    // Storage: reset clears every entry, otherwise one write per cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Reads see pre-edge contents, so a write is never forwarded.
    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];
    assign rdata_c_o = mem_q[raddr_c_i];

endmodule

// File: rtl/ecc_alu_sequencer.sv
// ecc_alu_sequencer
// Command sequencer in front of the GF(2^128) ALU. Owns the operand
// register file, accepts register-to-register commands, fetches operands,
// strobes exactly one ALU enable, waits for alu_done_i and writes back.
// A watchdog aborts a command whose ALU never answers.
// Ports:
//   clk_i, rst_ni                       clock / synchronous active-low reset
//   cmd_valid_i, cmd_ready_o            command handshake
//   cmd_op_i, cmd_src_a_i, cmd_src_b_i, cmd_dst_i   command fields
//   wr_en_i, wr_addr_i, wr_data_i       host register load
//   wr_drop_o                           pulse: host load ignored
//   rd_addr_i, rd_data_o                host combinational read
//   alu_da_o, alu_db_o                  registered ALU operands
//   alu_add_en_o, alu_mult_en_o, alu_sqr_en_o   one-cycle ALU start strobes
//   alu_result_i, alu_done_i            ALU result and completion pulse
//   busy_o, op_done_o                   status / command retired pulse
//   timeout_err_o, err_clr_i            sticky watchdog flag and its clear
module ecc_alu_sequencer
    import ecc_pkg::*;
#(
    parameter int DATA_W         = ECC_DATA_W,
    parameter int NREGS          = ECC_NREGS,
    parameter int AW             = ECC_AW,
    parameter int TIMEOUT_CYCLES = ECC_TIMEOUT_CYCLES
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [AW-1:0]     cmd_src_a_i,
    input  logic [AW-1:0]     cmd_src_b_i,
    input  logic [AW-1:0]     cmd_dst_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_drop_o,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [DATA_W-1:0] alu_da_o,
    output logic [DATA_W-1:0] alu_db_o,
    output logic              alu_mult_en_o,
    output logic              alu_add_en_o,
    output logic              alu_sqr_en_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_done_i,
    output logic              busy_o,
    output logic              op_done_o,
    output logic              timeout_err_o,
    input  logic              err_clr_i
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     dst_q, dst_d;
    logic [DATA_W-1:0] da_q, da_d;
    logic [DATA_W-1:0] db_q, db_d;
    logic              addEn_q, addEn_d;
    logic              multEn_q, multEn_d;
    logic              sqrEn_q, sqrEn_d;
    logic [CW-1:0]     count_q, count_d;
    logic              opDone_q, opDone_d;
    logic              wrDrop_q, wrDrop_d;
    logic              timeoutErr_q, timeoutErr_d;

    logic              rfWe;
    logic [AW-1:0]     rfWaddr;
    logic [DATA_W-1:0] rfWdata;
    logic [DATA_W-1:0] srcAData;
    logic [DATA_W-1:0] srcBData;

    ecc_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .AW     (AW)
    ) u_regfile (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .we_i      (rfWe),
        .waddr_i   (rfWaddr),
        .wdata_i   (rfWdata),
        .raddr_a_i (cmd_src_a_i),
        .rdata_a_o (srcAData),
        .raddr_b_i (cmd_src_b_i),
        .rdata_b_o (srcBData),
        .raddr_c_i (rd_addr_i),
        .rdata_c_o (rd_data_o)
    );

    // Next-state logic. The register file has one write port: in IDLE it
    // belongs to the host unless a MOV is accepted, in which case the MOV
    // takes it and the host load is reported as dropped. In WAIT it carries
    // the ALU write-back. count_q holds the number of WAIT cycles already
    // spent without alu_done, so the abort fires on the last allowed one.
    always_comb begin
        state_d      = state_q;
        dst_d        = dst_q;
        da_d         = da_q;
        db_d         = db_q;
        addEn_d      = 1'b0;
        multEn_d     = 1'b0;
        sqrEn_d      = 1'b0;
        count_d      = count_q;
        opDone_d     = 1'b0;
        wrDrop_d     = 1'b0;
        timeoutErr_d = timeoutErr_q & ~err_clr_i;
        rfWe         = 1'b0;
        rfWaddr      = wr_addr_i;
        rfWdata      = wr_data_i;

        case (state_q)
            S_IDLE: begin
                rfWe = wr_en_i;
                if (cmd_valid_i) begin
                    if (cmd_op_i == OP_MOV) begin
                        wrDrop_d = wr_en_i;
                        rfWe     = 1'b1;
                        rfWaddr  = cmd_dst_i;
                        rfWdata  = srcAData;
                        opDone_d = 1'b1;
                    end else begin
                        dst_d    = cmd_dst_i;
                        da_d     = srcAData;
                        db_d     = srcBData;
                        addEn_d  = (cmd_op_i == OP_ADD);
                        multEn_d = (cmd_op_i == OP_MULT);
                        sqrEn_d  = (cmd_op_i == OP_SQR);
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                wrDrop_d = wr_en_i;
                count_d  = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                wrDrop_d = wr_en_i;
                if (alu_done_i) begin
                    rfWe     = 1'b1;
                    rfWaddr  = dst_q;
                    rfWdata  = alu_result_i;
                    opDone_d = 1'b1;
                    state_d  = S_IDLE;
                end else if (count_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    timeoutErr_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, all cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            dst_q        <= '0;
            da_q         <= '0;
            db_q         <= '0;
            addEn_q      <= 1'b0;
            multEn_q     <= 1'b0;
            sqrEn_q      <= 1'b0;
            count_q      <= '0;
            opDone_q     <= 1'b0;
            wrDrop_q     <= 1'b0;
            timeoutErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dst_q        <= dst_d;
            da_q         <= da_d;
            db_q         <= db_d;
            addEn_q      <= addEn_d;
            multEn_q     <= multEn_d;
            sqrEn_q      <= sqrEn_d;
            count_q      <= count_d;
            opDone_q     <= opDone_d;
            wrDrop_q     <= wrDrop_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

    assign cmd_ready_o   = (state_q == S_IDLE) && rst_ni;
    assign busy_o        = (state_q != S_IDLE);
    assign alu_da_o      = da_q;
    assign alu_db_o      = db_q;
    assign alu_add_en_o  = addEn_q;
    assign alu_mult_en_o = multEn_q;
    assign alu_sqr_en_o  = sqrEn_q;
    assign op_done_o     = opDone_q;
    assign wr_drop_o     = wrDrop_q;
    assign timeout_err_o = timeoutErr_q;

endmodule

// File: tb/tb_ecc_alu_sequencer.sv
// tb_ecc_alu_sequencer
// Directed bench for ecc_alu_sequencer with a carry-less model ALU, a
// command-level reference model and a per-cycle compare process.
module tb_ecc_alu_sequencer;
    import ecc_pkg::*;

    localparam int DW = 128;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          cmdValid = 1'b0;
    logic          cmdReady;
    logic [1:0]    cmdOp = 2'b00;
    logic [2:0]    cmdSrcA = '0;
    logic [2:0]    cmdSrcB = '0;
    logic [2:0]    cmdDst = '0;
    logic          wrEn = 1'b0;
    logic [2:0]    wrAddr = '0;
    logic [DW-1:0] wrData = '0;
    logic          wrDrop;
    logic [2:0]    rdAddr = '0;
    logic [DW-1:0] rdData;
    logic [DW-1:0] aluDa;
    logic [DW-1:0] aluDb;
    logic          aluMultEn;
    logic          aluAddEn;
    logic          aluSqrEn;
    logic [DW-1:0] aluResult = '0;
    logic          aluDone = 1'b0;
    logic          busy;
    logic          opDone;
    logic          timeoutErr;
    logic          errClr = 1'b0;

    always #10 clk = ~clk;

    ecc_alu_sequencer #(
        .DATA_W         (DW),
        .NREGS          (8),
        .AW             (3),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .cmd_valid_i   (cmdValid),
        .cmd_ready_o   (cmdReady),
        .cmd_op_i      (cmdOp),
        .cmd_src_a_i   (cmdSrcA),
        .cmd_src_b_i   (cmdSrcB),
        .cmd_dst_i     (cmdDst),
        .wr_en_i       (wrEn),
        .wr_addr_i     (wrAddr),
        .wr_data_i     (wrData),
        .wr_drop_o     (wrDrop),
        .rd_addr_i     (rdAddr),
        .rd_data_o     (rdData),
        .alu_da_o      (aluDa),
        .alu_db_o      (aluDb),
        .alu_mult_en_o (aluMultEn),
        .alu_add_en_o  (aluAddEn),
        .alu_sqr_en_o  (aluSqrEn),
        .alu_result_i  (aluResult),
        .alu_done_i    (aluDone),
        .busy_o        (busy),
        .op_done_o     (opDone),
        .timeout_err_o (timeoutErr),
        .err_clr_i     (errClr)
    );

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state: register contents and the one outstanding
    // command, tracked at transaction level.
    logic [DW-1:0] mRegs [8];
    logic          mCheck = 1'b0;
    logic          mBusy = 1'b0;
    logic          mIssue = 1'b0;
    logic          mOpDone = 1'b0;
    logic          mWrDrop = 1'b0;
    logic          mTimeout = 1'b0;
    logic [1:0]    mOp = 2'b00;
    logic [2:0]    mDst = '0;
    logic [DW-1:0] mA = '0;
    logic [DW-1:0] mB = '0;
    int            mWaitCycles = 0;

    // Model ALU state.
    logic          aluHang = 1'b0;
    int            aluCount = 0;
    logic [DW-1:0] aluRes = '0;

    function automatic logic [DW-1:0] clmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DW; i++) begin
            if (b[i]) r = r ^ (a << i);
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] aluRef(input logic [1:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        if (op == OP_ADD) return a ^ b;
        if (op == OP_MULT) return clmul(a, b);
        return clmul(a, a);
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    endtask

    // Reference model step for one rising edge, using the inputs that were
    // stable during the cycle that edge closes.
    task automatic modelEdge();
        logic [DW-1:0] fetchA;
        logic [DW-1:0] fetchB;
        logic          timeoutNow;
        timeoutNow = 1'b0;
        mOpDone = 1'b0;
        mWrDrop = 1'b0;
        if (!rstN) begin
            for (int i = 0; i < 8; i++) mRegs[i] = '0;
            mBusy    = 1'b0;
            mIssue   = 1'b0;
            mTimeout = 1'b0;
            mCheck   = 1'b1;
        end else begin
            if (mBusy) begin
                mWrDrop = wrEn;
                if (mIssue) begin
                    mIssue = 1'b0;
                    mWaitCycles = 0;
                end else if (aluDone) begin
                    mRegs[mDst] = aluRef(mOp, mA, mB);
                    mOpDone = 1'b1;
                    mBusy = 1'b0;
                end else begin
                    mWaitCycles++;
                    if (mWaitCycles == TO) begin
                        timeoutNow = 1'b1;
                        mBusy = 1'b0;
                    end
                end
            end else begin
                fetchA = mRegs[cmdSrcA];
                fetchB = mRegs[cmdSrcB];
                if (cmdValid && cmdOp == OP_MOV) begin
                    mWrDrop = wrEn;
                    mRegs[cmdDst] = fetchA;
                    mOpDone = 1'b1;
                end else begin
                    if (wrEn) mRegs[wrAddr] = wrData;
                    if (cmdValid) begin
                        mBusy  = 1'b1;
                        mIssue = 1'b1;
                        mOp    = cmdOp;
                        mDst   = cmdDst;
                        mA     = fetchA;
                        mB     = fetchB;
                    end
                end
            end
            if (timeoutNow) mTimeout = 1'b1;
            else if (errClr) mTimeout = 1'b0;
        end
    endtask

    // Model ALU: ADD/SQR answer two cycles after the strobe, MULT after 68.
    task automatic aluModel();
        aluDone = 1'b0;
        if (aluCount > 0) begin
            aluCount--;
            if (aluCount == 0) begin
                aluDone = 1'b1;
                aluResult = aluRes;
            end
        end
        if ((aluAddEn || aluMultEn || aluSqrEn) && !aluHang) begin
            aluCount = aluMultEn ? 68 : 2;
            if (aluAddEn) aluRes = aluDa ^ aluDb;
            else if (aluMultEn) aluRes = clmul(aluDa, aluDb);
            else aluRes = clmul(aluDa, aluDa);
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        modelEdge();
        #1;
        aluModel();
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (mBusy && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput("idle within budget", {{(DW-1){1'b0}}, mBusy}, '0);
    endtask

    task automatic issueCmd(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                            input logic [2:0] d);
        cmdValid = 1'b1;
        cmdOp = op;
        cmdSrcA = a;
        cmdSrcB = b;
        cmdDst = d;
        applyStimulus();
        cmdValid = 1'b0;
    endtask

    task automatic hostWrite(input logic [2:0] a, input logic [DW-1:0] d);
        wrEn = 1'b1;
        wrAddr = a;
        wrData = d;
        applyStimulus();
        wrEn = 1'b0;
    endtask

    task automatic checkReg(input logic [2:0] a, input logic [DW-1:0] exp);
        rdAddr = a;
        #1;
        checkOutput($sformatf("R%0d literal", a), rdData, exp);
    endtask

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge clk) begin
        if (mCheck) begin
            checkOutput("cmd_ready", cmdReady, rstN && !mBusy);
            checkOutput("busy", busy, mBusy);
            checkOutput("op_done", opDone, mOpDone);
            checkOutput("wr_drop", wrDrop, mWrDrop);
            checkOutput("timeout_err", timeoutErr, mTimeout);
            checkOutput("rd_data", rdData, mRegs[rdAddr]);
            checkOutput("strobes {add,mult,sqr}", {aluAddEn, aluMultEn, aluSqrEn},
                        (mBusy && mIssue) ? {mOp == OP_ADD, mOp == OP_MULT, mOp == OP_SQR} : 3'b000);
            if (mBusy) begin
                checkOutput("alu_da", aluDa, mA);
                checkOutput("alu_db", aluDb, mB);
            end
        end
    end

    initial begin
        repeat (3) applyStimulus();
        rstN = 1'b1;
        applyStimulus();
        checkReg(3'd0, 128'h0);

        // ADD R3 = R1 + R2
        hostWrite(3'd1, 128'h3);
        hostWrite(3'd2, 128'h5);
        issueCmd(OP_ADD, 3'd1, 3'd2, 3'd3);
        checkOutput("add strobe literal", aluAddEn, 1'b1);
        checkOutput("da literal", aluDa, 128'h3);
        checkOutput("db literal", aluDb, 128'h5);
        waitIdle(20);
        checkOutput("add op_done literal", opDone, 1'b1);
        checkReg(3'd3, 128'h6);
        applyStimulus();

        // MULT R4 = R1 * R2
        issueCmd(OP_MULT, 3'd1, 3'd2, 3'd4);
        checkOutput("mult strobe literal", aluMultEn, 1'b1);
        checkOutput("ready low in mult literal", cmdReady, 1'b0);
        waitIdle(100);
        checkOutput("ready at mult op_done literal", cmdReady, 1'b1);
        checkReg(3'd4, 128'hF);

        // Back-to-back MOVs
        cmdValid = 1'b1;
        cmdOp = OP_MOV;
        cmdSrcA = 3'd1;
        cmdDst = 3'd5;
        applyStimulus();
        cmdSrcA = 3'd5;
        cmdDst = 3'd6;
        applyStimulus();
        cmdValid = 1'b0;
        checkOutput("second mov op_done literal", opDone, 1'b1);
        checkReg(3'd5, 128'h3);
        checkReg(3'd6, 128'h3);
        applyStimulus();

        // SQR R7 = R2^2
        issueCmd(OP_SQR, 3'd2, 3'd0, 3'd7);
        waitIdle(20);
        checkReg(3'd7, 128'h11);
        applyStimulus();

        // Watchdog
        aluHang = 1'b1;
        issueCmd(OP_ADD, 3'd1, 3'd2, 3'd3);
        waitIdle(400);
        checkOutput("timeout set literal", timeoutErr, 1'b1);
        checkOutput("no op_done on timeout literal", opDone, 1'b0);
        checkReg(3'd3, 128'h6);
        aluHang = 1'b0;
        issueCmd(OP_ADD, 3'd1, 3'd2, 3'd0);
        waitIdle(20);
        checkReg(3'd0, 128'h6);
        checkOutput("timeout still set literal", timeoutErr, 1'b1);
        errClr = 1'b1;
        applyStimulus();
        errClr = 1'b0;
        checkOutput("timeout cleared literal", timeoutErr, 1'b0);

        // Clear coinciding with the timeout leaves the flag set
        aluHang = 1'b1;
        issueCmd(OP_ADD, 3'd1, 3'd2, 3'd3);
        errClr = 1'b1;
        waitIdle(400);
        errClr = 1'b0;
        checkOutput("timeout wins over clear literal", timeoutErr, 1'b1);
        aluHang = 1'b0;
        errClr = 1'b1;
        applyStimulus();
        errClr = 1'b0;

        // Host load while busy is dropped
        issueCmd(OP_MULT, 3'd1, 3'd2, 3'd4);
        repeat (5) applyStimulus();
        hostWrite(3'd1, 128'hFF);
        checkOutput("wr_drop literal", wrDrop, 1'b1);
        waitIdle(100);
        checkReg(3'd1, 128'h3);
        applyStimulus();
        hostWrite(3'd1, 128'hFF);
        checkOutput("no wr_drop idle literal", wrDrop, 1'b0);
        checkReg(3'd1, 128'hFF);

        // MOV beats a same-address host load
        wrEn = 1'b1;
        wrAddr = 3'd2;
        wrData = 128'hAA;
        issueCmd(OP_MOV, 3'd1, 3'd0, 3'd2);
        wrEn = 1'b0;
        checkReg(3'd2, 128'hFF);

        // Same-cycle host write to a source is not forwarded
        wrEn = 1'b1;
        wrAddr = 3'd1;
        wrData = 128'h10;
        issueCmd(OP_ADD, 3'd1, 3'd2, 3'd5);
        wrEn = 1'b0;
        checkOutput("no forward da literal", aluDa, 128'hFF);
        waitIdle(20);
        checkReg(3'd5, 128'h0);
        checkReg(3'd1, 128'h10);
        applyStimulus();

        // Reset in the middle of a MULT; late alu_done must be ignored
        issueCmd(OP_MULT, 3'd1, 3'd2, 3'd4);
        repeat (10) applyStimulus();
        rstN = 1'b0;
        repeat (2) applyStimulus();
        rstN = 1'b1;
        repeat (70) applyStimulus();
        for (int i = 0; i < 8; i++) checkReg(3'(i), 128'h0);
        checkOutput("ready after reset literal", cmdReady, 1'b1);
        checkOutput("no op_done after reset literal", opDone, 1'b0);
        applyStimulus();

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ecc_alu_sequencer.md
Name: ecc_alu_sequencer

Overview:
Command sequencer directly upstream of the 128-bit GF(2^128) ALU. It owns an 8-entry x 128-bit operand register file and accepts register-to-register commands over a valid/ready handshake. For each command it fetches operands, pulses exactly one ALU enable, waits for the ALU done pulse and writes the result back. A watchdog catches an ALU that never completes. Point-arithmetic control logic sits above it.

Parameters:
DATA_W, 128, operand/result width
NREGS, 8, register file depth
AW, 3, register address width (log2 NREGS)
TIMEOUT_CYCLES, 255, maximum S_WAIT cycles before abort (must be > 70)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, synchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&&ready
cmd_op  in  2  00 ADD, 01 MULT, 10 SQR, 11 MOV
cmd_src_a  in  AW  source A register
cmd_src_b  in  AW  source B register (ignored for SQR/MOV)
cmd_dst  in  AW  destination register
wr_en  in  1  host register load
wr_addr  in  AW  host load address
wr_data  in  DATA_W  host load data
wr_drop  out  1  1-cycle pulse: host load ignored because busy
rd_addr  in  AW  host read address
rd_data  out  DATA_W  combinational read of reg[rd_addr]
alu_da  out  DATA_W  ALU operand A (registered)
alu_db  out  DATA_W  ALU operand B (registered)
alu_mult_en, alu_add_en, alu_sqr_en  out  1 each  ALU start strobes
alu_result  in  DATA_W  ALU result
alu_done  in  1  ALU completion pulse
busy  out  1  state != S_IDLE
op_done  out  1  1-cycle pulse: command retired, dst updated
timeout_err  out  1  sticky watchdog flag
err_clr  in  1  clears timeout_err

Behaviour:
- Reset: synchronous, active-low. On any clk edge with rst=0: state=S_IDLE, all registers and outputs 0, all regfile entries 0, timeout counter 0. cmd_ready=0 while rst=0. Applies mid-operation. An alu_done arriving after reset is ignored.
- States: S_IDLE, S_ISSUE, S_WAIT. cmd_ready = (state==S_IDLE) && rst.
- S_IDLE, accept of ADD/MULT/SQR:
  - Latch op and dst.
  - alu_da<=reg[src_a]; alu_db<=reg[src_b].
  - Go to S_ISSUE.
- S_IDLE, accept of MOV:
  - reg[dst]<=reg[src_a]; op_done=1 next cycle.
  - Stay in S_IDLE, so back-to-back MOVs run at 1 per cycle.
- S_ISSUE (exactly 1 cycle):
  - Assert exactly one strobe from op; strobe is registered and high only this cycle.
  - Clear timeout counter. Go to S_WAIT.
- S_WAIT:
  - alu_da/alu_db held stable.
  - On alu_done: reg[dst]<=alu_result. op_done=1 in the following cycle, together with visibility of the new value on rd_data. Go to S_IDLE.
  - Otherwise counter increments. When the counter reaches TIMEOUT_CYCLES: set timeout_err, perform no write, pulse no op_done, go to S_IDLE.
- Command latency: ADD is accepted at cycle 0; strobe at 1; ALU done at about 3; op_done at about 4. MULT is about 70 cycles.
- alu_done in S_IDLE or S_ISSUE is ignored.
- Host load: wr_en in S_IDLE writes reg[wr_addr]. If a MOV is accepted in the same cycle with dst==wr_addr, the MOV wins. wr_en while busy is dropped and wr_drop pulses.
- Operand fetch reads pre-edge register contents. A same-cycle host write to a source register is not forwarded.
- timeout_err: stays set until err_clr=1 or reset. err_clr and a timeout in the same cycle leave the flag set. Commands are still accepted while the flag is set.
- src==dst is legal; the result overwrites the source.

Decomposition:
- Package ecc_pkg:
  - DATA_W and AW constants.
  - Opcode constants OP_ADD/OP_MULT/OP_SQR/OP_MOV.
  - State encoding S_IDLE/S_ISSUE/S_WAIT.
  - Default TIMEOUT_CYCLES.
- Sub-module ecc_regfile:
  - NREGS x DATA_W.
  - One synchronous write port with synchronous active-low clear.
  - Three combinational read ports (src_a, src_b, rd_addr).
- Sequencer FSM, strobes, operand registers and watchdog stay in ecc_alu_sequencer.

Test Plan:
- Load R1=0x3, R2=0x5; ADD dst R3 -> alu_add_en high exactly 1 cycle with da=0x3, db=0x5; R3=0x6; op_done 1 cycle after alu_done.
- Same loads, MULT dst R4 with a carry-less model ALU -> R4=0xF; alu_mult_en only strobe; cmd_ready=0 until op_done cycle.
- MOV R5<=R1 then MOV R6<=R5 on consecutive cycles -> R5=R6=0x3; two op_done pulses; cmd_ready stays 1.
- Model never asserts alu_done -> timeout_err=1 after 255 S_WAIT cycles; dst unchanged; no op_done; next ADD completes normally; err_clr clears the flag.
- wr_en to R1=0xFF during MULT wait -> wr_drop pulses, R1 still 0x3. Same load in S_IDLE -> R1=0xFF.
- rst=0 mid-MULT, then alu_done after release -> all regs 0, no write, no op_done, cmd_ready=1.
